// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - sequential N x N shift-and-add multiplier driving an external N-bit adder
// Optional SEQ_MUL_OVF_EN adds an ovf output flagging products wider than N bits.
module seq_shift_add_mul #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   add_x,
  output logic [N-1:0]   add_y,
  output logic           add_ci,
  input  logic [N-1:0]   add_s,
  input  logic           add_cu,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
`ifdef SEQ_MUL_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0]   hi, lo, hi_n;
  logic           c;
`ifdef SEQ_MUL_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  assign hi = acc_q[2*N-1:N];
  assign lo = acc_q[N-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    count_d = count_q;
    p_d     = p_q;
    c       = 1'b0;
    hi_n    = hi;
`ifdef SEQ_MUL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      RUN: begin
        // adder carry becomes the shift-in bit, so the full product is preserved
        if (lo[0]) begin
          c    = add_cu;
          hi_n = add_s;
        end
        acc_d   = {c, hi_n, lo[N-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
          p_d     = acc_d;
`ifdef SEQ_MUL_OVF_EN
          ovf_d   = |acc_d[2*N-1:N];
`endif
        end
      end
      default: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{N{1'b0}}, b};
          count_d = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

`ifdef SEQ_MUL_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign add_x  = hi;
  assign add_y  = mcand_q;
  assign add_ci = 1'b0;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign p      = p_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb/tb_seq_shift_add_mul.sv - scoreboard bench for seq_shift_add_mul with a behavioural adder
module tb_seq_shift_add_mul;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [N-1:0]   add_x, add_y, add_s;
  logic           add_ci, add_cu;
  logic           busy, done;
  logic [2*N-1:0] p;
`ifdef SEQ_MUL_OVF_EN
  logic           ovf;
`endif

  typedef struct packed {
    logic [2*N-1:0] prod;
    logic           ovf;
  } exp_t;

  exp_t           sb_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             n_push = 0;
  int             n_done = 0;
  logic [2*N-1:0] last_p = '0;

  seq_shift_add_mul #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .add_x  (add_x),
    .add_y  (add_y),
    .add_ci (add_ci),
    .add_s  (add_s),
    .add_cu (add_cu),
    .busy   (busy),
    .done   (done),
    .p      (p)
`ifdef SEQ_MUL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  assign {add_cu, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_ci};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || busy) chk("done_busy_exclusive", {31'd0, done && busy}, 32'd0);
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("product", {24'd0, p}, {24'd0, e.prod});
`ifdef SEQ_MUL_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        end
      end
    end
  end

  // called at a negedge; returns at the negedge of the DONE cycle
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [2*N-1:0] prod, input bit hold_start);
    exp_t e;
    logic [2*N-1:0] prev_p;
    prev_p = last_p;
    start = 1'b1;
    a = ia;
    b = ib;
    e.prod = prod;
    e.ovf  = (prod > 8'd15);
    sb_q.push_back(e);
    n_push++;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (!hold_start || i == N - 1) start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      chk("busy_in_run", {31'd0, busy}, 32'd1);
      chk("no_done_in_run", {31'd0, done}, 32'd0);
      chk("p_held", {24'd0, p}, {24'd0, prev_p});
    end
    @(negedge clk);
    chk("done_at_latency", {31'd0, done}, 32'd1);
    chk("busy_off_in_done", {31'd0, busy}, 32'd0);
    last_p = prod;
  endtask

  task automatic idle_check;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
    chk("p_held_idle", {24'd0, p}, {24'd0, last_p});
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_p", {24'd0, p}, 32'd0);
    chk("rst_add_x", {28'd0, add_x}, 32'd0);
    chk("rst_add_y", {28'd0, add_y}, 32'd0);
    chk("rst_add_ci", {31'd0, add_ci}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd3, 4'd5, 8'h0F, 1'b0);
    idle_check();
    run_op(4'd15, 4'd15, 8'hE1, 1'b0);
    idle_check();
    run_op(4'd0, 4'd9, 8'h00, 1'b1);
    idle_check();
    run_op(4'd9, 4'd0, 8'h00, 1'b1);
    idle_check();
    run_op(4'd10, 4'd12, 8'h78, 1'b0);
    // back-to-back: start issued during the DONE cycle
    run_op(4'd2, 4'd7, 8'h0E, 1'b0);
    idle_check();
    run_op(4'd1, 4'd15, 8'h0F, 1'b0);
    idle_check();

    // async reset in the middle of an operation at count=2
    start = 1'b1;
    a = 4'd5;
    b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_p", {24'd0, p}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_p = '0;
    for (int i = 0; i < N + 2; i++) idle_check();

    @(negedge clk);
    run_op(4'd6, 4'd6, 8'h24, 1'b0);
    idle_check();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    chk("done_count", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
